fsm_burst_rd: RTL

Parametrised successor to the single-beat read handshake FSM. It sequences a burst of 1..2^BURST_W read beats from one `go` request. Each beat uses the rd/ws wait-state handshake. The block adds a wait-state timeout with error reporting, a synchronous abort, a busy flag and a beat index. It sits between a request source and a slow read target. All outputs are registered and decoded from the next state.

---
 rtl/fsm_burst_rd.sv | 94 +++++++++
 1 files changed

// File: rtl/fsm_burst_rd.sv
// fsm_burst_rd: burst read sequencer with wait-state retry, timeout error, abort, busy and beat index
module fsm_burst_rd #(
  parameter int BURST_W = 4,
  parameter int TMO_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [BURST_W-1:0] len,
  input  logic               ws,
  input  logic               abort,
  output logic               rd,
  output logic               ds,
  output logic               err,
  output logic               busy,
  output logic [BURST_W-1:0] beat
);
  typedef enum logic [2:0] {IDLE, READ, DLY, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [BURST_W-1:0] beat_q, beat_d, len_q, len_d;
  logic [TMO_W-1:0] wcnt_q, wcnt_d;
  logic rd_q, rd_d, ds_q, ds_d, err_q, err_d, busy_q, busy_d;
  // state, counters and outputs all register the next-state view
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      rd_q    <= 1'b0;
      ds_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      rd_q    <= rd_d;
      ds_q    <= ds_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end
  // next state: abort wins, a ws-high sample retries the beat until the timeout budget is spent
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    if (abort) begin
      state_d = IDLE;
      beat_d  = '0;
      wcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (go) begin
          state_d = READ;
          len_d   = len;
          beat_d  = '0;
          wcnt_d  = '0;
        end
        READ: state_d = DLY;
        DLY: if (!ws) begin
          wcnt_d  = '0;
          state_d = (beat_q == len_q) ? DONE : READ;
          beat_d  = (beat_q == len_q) ? beat_q : beat_q + 1'b1;
        end else begin
          state_d = (wcnt_q == TMO_W'(TIMEOUT - 1)) ? ERR : READ;
          wcnt_d  = (wcnt_q == TMO_W'(TIMEOUT - 1)) ? wcnt_q : wcnt_q + 1'b1;
        end
        DONE, ERR: state_d = IDLE;
        default: begin
          state_d = IDLE;
          beat_d  = '0;
          wcnt_d  = '0;
        end
      endcase
    end
  end
  // output decode from the next state so every strobe leaves a flop
  always_comb begin
    rd_d   = (state_d == READ) || (state_d == DLY);
    ds_d   = state_d == DONE;
    err_d  = state_d == ERR;
    busy_d = state_d != IDLE;
  end
  assign rd   = rd_q;
  assign ds   = ds_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign beat = beat_q;
endmodule
